id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32I core; it consumes the stall/flush controls produced by the hazard logic.
- Captures decode-stage operands and control each cycle, inserting a bubble on stall or flush.
- Presents the registered E-stage fields the hazard logic inspects: rs1_e, rs2_e, rd_e, mem_read_e.
- Applies the forward_a_e/forward_b_e selects to build the final ALU operands and store data.

Parameters:
XLEN, 32, datapath width (operands, PC, immediate)
ALU_CTRL_W, 4, width of ALU control field

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  load-use stall; insert bubble into E
flush  in  1  branch/jump redirect; insert bubble into E
valid_d  in  1  D-stage holds a real instruction
pc_d  in  XLEN  D-stage PC
rd1_d, rd2_d  in  XLEN each  register-file read data
imm_d  in  XLEN  extended immediate
rs1_d, rs2_d, rd_d  in  5 each  register indices
reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, alu_src_d  in  1 each  D control
result_src_d  in  2  writeback source select
alu_ctrl_d  in  ALU_CTRL_W  ALU operation
forward_a_e, forward_b_e  in  2 each  operand forwarding selects
alu_result_m  in  XLEN  M-stage ALU result
result_w  in  XLEN  W-stage writeback value
valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e  out  as D  registered fields
reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e, result_src_e, alu_ctrl_e  out  as D  registered control
src_a_e  out  XLEN  forwarded ALU operand A
src_b_e  out  XLEN  ALU operand B, after alu_src mux
write_data_e  out  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset (rst=1 at edge):
  - All registered outputs become 0.
  - valid_e=0 and all control outputs are 0, so rs1_e/rs2_e/rd_e=0 never match a real hazard.
- Normal capture (rst=0, stall=0, flush=0):
  - Every *_d field is copied to its *_e register; latency is exactly 1 cycle.
- Bubble (rst=0 and (stall|flush)=1):
  - Next state has valid_e=0 and all of reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e, result_src_e, alu_ctrl_e = 0.
  - rs1_e, rs2_e, rd_e = 0; pc_e, imm_e and the registered rd1/rd2 = 0.
  - A bubble is an architectural NOP: it never writes a register or memory.
- Priority: rst > flush = stall (either one, or both together, gives an identical bubble).
- The stage never holds its own contents. The upstream IF/ID register handles holding; on stall this stage drains to a bubble.
- An instruction arriving with valid_d=0 is captured as-is. Its control fields are expected to be 0; the stage gates nothing extra.
- Forwarding muxes, combinational from the registered values:
  - forward_a_e: 00 → registered rd1; 01 → result_w; 10 → alu_result_m; 11 → registered rd1 (reserved, treated as 00).
  - forward_b_e selects identically using registered rd2, giving write_data_e.
  - src_a_e = forwarded A.
  - src_b_e = imm_e when alu_src_e=1, otherwise write_data_e.
- Widths: all datapath values are XLEN with no extension or truncation inside this block. Register index x0 gets no special handling here.
- Reset asserted mid-stream clears the stage the same cycle. The first instruction after deassert is captured normally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - bubble_stall_cnt (32): counts cycles with stall=1 and flush=0.
  - bubble_flush_cnt (32): counts cycles with flush=1, including when stall is also 1.
- Counter rules: both clear on rst, saturate at 0xFFFFFFFF, and increment only while rst=0.
- When undefined: the ports and counters are absent, and stage behaviour is identical.

Test Plan:
- Capture: rst 2 cycles, then pc_d=0x100, rd1_d=5, rd2_d=7, rd_d=3, reg_write_d=1 → next cycle pc_e=0x100, rd_e=3, reg_write_e=1, valid_e=1, src_a_e=5.
- Load-use bubble: mem_read_d=1, rd_d=6 captured; next cycle stall=1 → following cycle valid_e=0, rd_e=0, mem_read_e=0, reg_write_e=0.
- Flush: branch instruction in D with flush=1 and stall=1 together → single bubble, all control_e=0; the next un-stalled instruction captures normally.
- Forwarding: rd1 registered 0x11, alu_result_m=0x22, result_w=0x33 → forward_a_e=00/01/10/11 gives src_a_e=0x11/0x33/0x22/0x11.
- Operand B: alu_src_e=1, imm_e=0xFFFFFFF0, forward_b_e=10, alu_result_m=0x44 → src_b_e=0xFFFFFFF0 and write_data_e=0x44.
- Perf (ID_EX_PERF_CNT_EN): 3 stall-only cycles and 2 flush cycles (one with stall=1), then rst → counts read 3 and 2, then both read 0 the cycle after rst.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 5-stage RV32I core.
// Captures D-stage operands and control every cycle, drains to a bubble on
// stall or flush, and builds the forwarded ALU operands and store data.
// Optional build macro: ID_EX_PERF_CNT_EN adds bubble_stall_cnt and
// bubble_flush_cnt saturating bubble counters.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_d,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic [4:0]            rd_d,
  input  logic                  reg_write_d,
  input  logic                  mem_read_d,
  input  logic                  mem_write_d,
  input  logic                  branch_d,
  input  logic                  jump_d,
  input  logic                  alu_src_d,
  input  logic [1:0]            result_src_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  input  logic [1:0]            forward_a_e,
  input  logic [1:0]            forward_b_e,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       result_w,
  output logic                  valid_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       imm_e,
  output logic [4:0]            rs1_e,
  output logic [4:0]            rs2_e,
  output logic [4:0]            rd_e,
  output logic                  reg_write_e,
  output logic                  mem_read_e,
  output logic                  mem_write_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic [1:0]            result_src_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [XLEN-1:0]       src_a_e,
  output logic [XLEN-1:0]       src_b_e,
  output logic [XLEN-1:0]       write_data_e
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           bubble_stall_cnt,
  output logic [31:0]           bubble_flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // Next stage contents: copy D fields, or an all-zero bubble on stall/flush
  always_comb begin
    stage_d = '0;
    if (!(stall || flush)) begin
      stage_d.valid      = valid_d;
      stage_d.pc         = pc_d;
      stage_d.rd1        = rd1_d;
      stage_d.rd2        = rd2_d;
      stage_d.imm        = imm_d;
      stage_d.rs1        = rs1_d;
      stage_d.rs2        = rs2_d;
      stage_d.rd         = rd_d;
      stage_d.reg_write  = reg_write_d;
      stage_d.mem_read   = mem_read_d;
      stage_d.mem_write  = mem_write_d;
      stage_d.branch     = branch_d;
      stage_d.jump       = jump_d;
      stage_d.alu_src    = alu_src_d;
      stage_d.result_src = result_src_d;
      stage_d.alu_ctrl   = alu_ctrl_d;
    end
  end

  // Pipeline register; reset clears everything so E looks like a bubble
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  // Forwarding muxes; the reserved select 11 falls back to the register value
  always_comb begin
    fwd_a = stage_q.rd1;
    fwd_b = stage_q.rd2;
    case (forward_a_e)
      2'b01:   fwd_a = result_w;
      2'b10:   fwd_a = alu_result_m;
      default: fwd_a = stage_q.rd1;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = stage_q.rd2;
    endcase
  end

  assign src_a_e      = fwd_a;
  assign write_data_e = fwd_b;
  assign src_b_e      = stage_q.alu_src ? stage_q.imm : fwd_b;

  assign valid_e      = stage_q.valid;
  assign pc_e         = stage_q.pc;
  assign imm_e        = stage_q.imm;
  assign rs1_e        = stage_q.rs1;
  assign rs2_e        = stage_q.rs2;
  assign rd_e         = stage_q.rd;
  assign reg_write_e  = stage_q.reg_write;
  assign mem_read_e   = stage_q.mem_read;
  assign mem_write_e  = stage_q.mem_write;
  assign branch_e     = stage_q.branch;
  assign jump_e       = stage_q.jump;
  assign result_src_e = stage_q.result_src;
  assign alu_ctrl_e   = stage_q.alu_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating bubble counters; a flush wins the attribution when both are set
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
    if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bubble_stall_cnt = stall_cnt_q;
  assign bubble_flush_cnt = flush_cnt_q;
`endif

endmodule
